// File: rtl/stream_demux_if.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux_if
// Description : Handshake bundle for stream_demux. One input stream and
//               N_OUT output channels that share a data/last bus.
// Revision    : 1.0 - initial release
// ============================================================================
interface stream_demux_if #(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 8
);
    localparam int SEL_W = ($clog2(N_OUT) > 1) ? $clog2(N_OUT) : 1;

    logic [DATA_W-1:0] in_data;
    logic [SEL_W-1:0]  in_sel;
    logic              in_last;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic [N_OUT-1:0]  out_valid;
    logic [N_OUT-1:0]  out_ready;
    logic [7:0]        drop_cnt;
    logic              busy;

    modport master (
        output in_data, in_sel, in_last, in_valid, out_ready,
        input  in_ready, out_data, out_last, out_valid, drop_cnt, busy
    );

    modport slave (
        input  in_data, in_sel, in_last, in_valid, out_ready,
        output in_ready, out_data, out_last, out_valid, drop_cnt, busy
    );
endinterface
`default_nettype wire

// File: rtl/stream_demux.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux
// Description : Packet demultiplexer. The first beat's select locks the
//               destination channel for the whole packet; out-of-range
//               packets are discarded and counted.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_demux #(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 8
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    stream_demux_if.slave  bus
);
    localparam int SEL_W = ($clog2(N_OUT) > 1) ? $clog2(N_OUT) : 1;
    localparam logic [SEL_W:0] c_n_out = (SEL_W + 1)'(N_OUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_full;
    logic [DATA_W-1:0] r_data;
    logic              r_last;
    logic [SEL_W-1:0]  r_ch;
    logic [7:0]        r_drop_cnt;

    logic              w_in_range;
    logic              w_release;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_fwd;
    logic              w_drop_new;
    logic [N_OUT-1:0]  w_out_valid;

    // One extra bit so the compare is meaningful even when N_OUT is 2**SEL_W.
    assign w_in_range = ({1'b0, bus.in_sel} < c_n_out);

    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_out_valid
        assign w_out_valid[gi] = r_full && (r_ch == SEL_W'(gi));
    end

    // Only the held channel has a valid bit, so other ready bits fall out here.
    assign w_release  = |(w_out_valid & bus.out_ready);
    assign w_in_ready = rst_n && ((r_state == DROP) || !r_full || w_release);
    assign w_accept   = bus.in_valid && w_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fwd       = 1'b0;
        w_drop_new  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_in_range) begin
                        w_fwd = 1'b1;
                        if (!bus.in_last) w_state_nxt = FWD;
                    end else begin
                        w_drop_new = 1'b1;
                        if (!bus.in_last) w_state_nxt = DROP;
                    end
                end
            end
            FWD: begin
                if (w_accept) begin
                    w_fwd = 1'b1;
                    if (bus.in_last) w_state_nxt = IDLE;
                end
            end
            DROP: begin
                if (w_accept && bus.in_last) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // A forwarded beat overrides a same-cycle release: the register stays full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 1'b0;
            r_data <= '0;
            r_last <= 1'b0;
            r_ch   <= '0;
        end else if (w_fwd) begin
            r_full <= 1'b1;
            r_data <= bus.in_data;
            r_last <= bus.in_last;
            if (r_state == IDLE) r_ch <= bus.in_sel;
        end else if (w_release) begin
            r_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= 8'd0;
        end else if (w_drop_new && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_data;
    assign bus.out_last  = r_last;
    assign bus.out_valid = w_out_valid;
    assign bus.drop_cnt  = r_drop_cnt;
    assign bus.busy      = (r_state != IDLE) || r_full;

endmodule
`default_nettype wire
